// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word behind a one-deep valid/ready stage.
// Define IMM_CHECK_EN to substitute a NOP for immediates that are out of range or misaligned for their format.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [29:0] wcnt;
  logic [31:0] w_r, w_i, w_s, w_b, w_u, w_j, enc, next_instr;
  logic in_hs, out_hs, range_err, bad;
  assign out_valid = (state == FULL);
  assign in_ready = !out_valid || out_ready;
  assign in_hs = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;
  assign out_addr = BASE_ADDR + {wcnt, 2'b00};
  assign w_r = {funct7, rs2, rs1, funct3, rd, opcode};
  assign w_i = {imm[11:0], rs1, funct3, rd, opcode};
  assign w_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  assign w_b = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  assign w_u = {imm[31:12], rd, opcode};
  assign w_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  assign enc = fmt == 3'd0 ? w_r :
               fmt == 3'd1 ? w_i :
               fmt == 3'd2 ? w_s :
               fmt == 3'd3 ? w_b :
               fmt == 3'd4 ? w_u : w_j;
`ifdef IMM_CHECK_EN
  // Range checks reduce to "all bits above the field's sign bit equal the sign bit".
  assign range_err = (fmt == 3'd1 || fmt == 3'd2) ? (imm[31:11] != {21{imm[11]}}) :
                     fmt == 3'd3 ? (imm[31:12] != {20{imm[12]}}) || imm[0] :
                     fmt == 3'd4 ? |imm[11:0] :
                     fmt == 3'd5 ? (imm[31:20] != {12{imm[20]}}) || imm[0] : 1'b0;
`else
  assign range_err = 1'b0;
`endif
  assign bad = (fmt[2] && fmt[1]) || range_err;
  assign next_instr = bad ? 32'h0000_0013 : enc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_instr <= '0;
      out_err   <= 1'b0;
      wcnt      <= '0;
      err_count <= '0;
    end else if (clear) begin
      state     <= EMPTY;
      out_instr <= '0;
      out_err   <= 1'b0;
      wcnt      <= '0;
      err_count <= '0;
    end else begin
      if (out_hs) begin
        wcnt <= wcnt + 30'd1;
        if (out_err && err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      end
      if (in_hs) begin
        state     <= FULL;
        out_instr <= next_instr;
        out_err   <= bad;
      end else if (out_hs) begin
        state <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder; expectations follow IMM_CHECK_EN when defined.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk, rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, out_instr, out_addr;
  logic [7:0] err_count;
  int tests = 0;
  int fails = 0;

  instr_encoder #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    tests++; if ({out_valid, out_err, out_instr} !== 34'd0) begin fails++; $display("FAIL reset_out got v=%b e=%b i=%h exp 0/0/0", out_valid, out_err, out_instr); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL reset_addr got %h exp %h", out_addr, BASE); end
    tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_i;
    set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'h123); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    tests++; if ({out_valid, out_err} !== 2'b10) begin fails++; $display("FAIL i_flags got v=%b e=%b exp v=1 e=0", out_valid, out_err); end
    tests++; if (out_instr !== 32'h12300093) begin fails++; $display("FAIL i_instr got %h exp 12300093", out_instr); end
    tests++; if (out_addr !== BASE) begin fails++; $display("FAIL i_addr got %h exp %h", out_addr, BASE); end
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL i_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    set_fields(2, 7'h23, 2, 0, 0, 5, 4, 32'hFFFFF89A); in_valid = 1'b1;
    @(negedge clk);
    tests++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h8842AD23, BASE + 32'd4}) begin fails++; $display("FAIL s_word got v=%b i=%h a=%h exp 1/8842ad23/%h", out_valid, out_instr, out_addr, BASE + 32'd4); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL s_in_ready got %b exp 1", in_ready); end
    set_fields(3, 7'h63, 0, 0, 0, 6, 7, 32'hFFFFFFE0);
    @(negedge clk); in_valid = 1'b0;
    tests++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'hFE7300E3, BASE + 32'd8}) begin fails++; $display("FAIL b_word got v=%b i=%h a=%h exp 1/fe7300e3/%h", out_valid, out_instr, out_addr, BASE + 32'd8); end
    @(negedge clk);
    tests++; if ({out_valid, out_addr} !== {1'b0, BASE + 32'd12}) begin fails++; $display("FAIL b2b_drain got v=%b a=%h exp 0/%h", out_valid, out_addr, BASE + 32'd12); end
  endtask

  task automatic test_uj;
    out_ready = 1'b1;
    set_fields(4, 7'h37, 0, 0, 8, 0, 0, 32'h12345000); in_valid = 1'b1;
    @(negedge clk);
    tests++; if ({out_valid, out_err, out_instr, out_addr} !== {2'b10, 32'h12345437, BASE + 32'd12}) begin fails++; $display("FAIL u_word got v=%b e=%b i=%h a=%h exp 1/0/12345437/%h", out_valid, out_err, out_instr, out_addr, BASE + 32'd12); end
    set_fields(5, 7'h6F, 0, 0, 1, 0, 0, 32'h800);
    @(negedge clk); in_valid = 1'b0;
    tests++; if ({out_valid, out_err, out_instr, out_addr} !== {2'b10, 32'h001000EF, BASE + 32'd16}) begin fails++; $display("FAIL j_word got v=%b e=%b i=%h a=%h exp 1/0/001000ef/%h", out_valid, out_err, out_instr, out_addr, BASE + 32'd16); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_fields(0, 7'h33, 0, 7'h20, 1, 2, 3, 32'h0); in_valid = 1'b1;
    @(negedge clk);
    set_fields(1, 7'h13, 0, 0, 2, 0, 0, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tests++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h403100B3, BASE + 32'd20}) begin fails++; $display("FAIL bp_hold[%0d] got v=%b i=%h a=%h exp 1/403100b3/%h", i, out_valid, out_instr, out_addr, BASE + 32'd20); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    tests++; if ({out_valid, out_addr} !== {1'b0, BASE + 32'd24}) begin fails++; $display("FAIL bp_release got v=%b a=%h exp 0/%h", out_valid, out_addr, BASE + 32'd24); end
    @(negedge clk);
    tests++; if ({out_valid, out_addr} !== {1'b0, BASE + 32'd24}) begin fails++; $display("FAIL bp_single got v=%b a=%h exp 0/%h", out_valid, out_addr, BASE + 32'd24); end
  endtask

  task automatic test_errors;
    logic [31:0] exp_b, exp_i;
    exp_b = CHK ? 32'h00000013 : 32'h80000063;
    exp_i = CHK ? 32'h00000013 : 32'h80000013;
    out_ready = 1'b1;
    set_fields(3, 7'h63, 0, 0, 0, 0, 0, 32'h1001); in_valid = 1'b1;
    @(negedge clk);
    tests++; if ({out_instr, out_err} !== {exp_b, CHK}) begin fails++; $display("FAIL err_b got i=%h e=%b exp %h/%b", out_instr, out_err, exp_b, CHK); end
    set_fields(1, 7'h13, 0, 0, 0, 0, 0, 32'h800);
    @(negedge clk);
    tests++; if ({out_instr, out_err} !== {exp_i, CHK}) begin fails++; $display("FAIL err_i got i=%h e=%b exp %h/%b", out_instr, out_err, exp_i, CHK); end
    set_fields(7, 7'h33, 0, 0, 1, 2, 3, 32'h0);
    @(negedge clk); in_valid = 1'b0;
    tests++; if ({out_instr, out_err, out_addr} !== {32'h00000013, 1'b1, BASE + 32'd32}) begin fails++; $display("FAIL err_fmt7 got i=%h e=%b a=%h exp 00000013/1/%h", out_instr, out_err, out_addr, BASE + 32'd32); end
    @(negedge clk);
    tests++; if (err_count !== (CHK ? 8'd3 : 8'd1)) begin fails++; $display("FAIL err_count got %0d exp %0d", err_count, CHK ? 3 : 1); end
  endtask

  task automatic test_clear;
    out_ready = 1'b0;
    set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'h123); in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b1; out_ready = 1'b1;
    set_fields(4, 7'h37, 0, 0, 8, 0, 0, 32'h12345000);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL clr_in_ready got %b exp 1", in_ready); end
    @(negedge clk); clear = 1'b0; in_valid = 1'b0;
    tests++; if ({out_valid, out_addr, err_count} !== {1'b0, BASE, 8'd0}) begin fails++; $display("FAIL clr_state got v=%b a=%h c=%0d exp 0/%h/0", out_valid, out_addr, err_count, BASE); end
    set_fields(1, 7'h13, 0, 0, 1, 0, 0, 32'h123); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    tests++; if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h12300093, BASE}) begin fails++; $display("FAIL clr_restart got v=%b i=%h a=%h exp 1/12300093/%h", out_valid, out_instr, out_addr, BASE); end
    @(negedge clk);
  endtask

  task automatic test_saturate;
    out_ready = 1'b1;
    set_fields(6, 7'h13, 0, 0, 0, 0, 0, 32'h0); in_valid = 1'b1;
    repeat (260) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (err_count !== 8'hFF) begin fails++; $display("FAIL sat_count got %0d exp 255", err_count); end
    tests++; if ({out_valid, out_addr} !== {1'b0, BASE + 32'd1044}) begin fails++; $display("FAIL sat_addr got v=%b a=%h exp 0/%h", out_valid, out_addr, BASE + 32'd1044); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    set_fields(0, 7'h33, 0, 7'h20, 1, 2, 3, 32'h0); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_full got v=%b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, out_instr, out_addr, err_count} !== {1'b0, 32'd0, BASE, 8'd0}) begin fails++; $display("FAIL rmid_async got v=%b i=%h a=%h c=%0d exp 0/0/%h/0", out_valid, out_instr, out_addr, err_count, BASE); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_after got v=%b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_i;
    test_back_to_back;
    test_uj;
    test_backpressure;
    test_errors;
    test_clear;
    test_saturate;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
